// File: rtl/mul_add_pkg.sv
// Shared types and constants for the mul_add_stage slice.
package mul_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_ELEMENT_WIDTH = 32;
  localparam int DEFAULT_NO_OF_UNITS   = 8;
  localparam int DEFAULT_EQUATIONS     = 9;
  localparam int DEFAULT_ADDRESS_WIDTH = 32;

  // Memory words needed to hold n results packed units to a word.
  function automatic int calc_words(input int n, input int units);
    return (n + units - 1) / units;
  endfunction

endpackage

// File: rtl/mul_add_lane.sv
// One lane of signed a*b+c with a product register followed by a sum register.
// MUL_ADD_SATURATE_EN clamps overflowing sums instead of wrapping them.
module mul_add_lane
  import mul_add_pkg::*;
#(
  parameter int element_width = DEFAULT_ELEMENT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     advance,
  input  logic                     live,
  input  logic [element_width-1:0] a,
  input  logic [element_width-1:0] b,
  input  logic [element_width-1:0] c,
  output logic [element_width-1:0] result
);

  localparam int W = element_width;

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   c_q;
  logic           live_q;
  logic [2*W:0]   sum_full;
  logic [W-1:0]   sum_next;

  // Sign-extending first makes the low 2W bits of an unsigned multiply the signed product.
  assign a_ext    = {{W{a[W-1]}}, a};
  assign b_ext    = {{W{b[W-1]}}, b};
  assign sum_full = {prod_q[2*W-1], prod_q} + {{(W+1){c_q[W-1]}}, c_q};

`ifdef MUL_ADD_SATURATE_EN
  always_comb begin
    sum_next = sum_full[W-1:0];
    if (sum_full[2*W:W-1] != {(W+2){sum_full[W-1]}}) begin
      sum_next = sum_full[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum_full[2*W:W];
  assign sum_next  = sum_full[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
      c_q    <= '0;
      live_q <= 1'b0;
      result <= '0;
    end else begin
      if (load) begin
        prod_q <= a_ext * b_ext;
        c_q    <= c;
        live_q <= live;
      end
      if (advance) begin
        result <= live_q ? sum_next : '0;
      end
    end
  end

endmodule

// File: rtl/mul_add_stage.sv
// Multiply-add stage: streams WORDS beats of packed lanes through a two-stage
// a*b+c pipeline into the result memory. MUL_ADD_SATURATE_EN enables clamping.
module mul_add_stage
  import mul_add_pkg::*;
#(
  parameter int element_width                   = DEFAULT_ELEMENT_WIDTH,
  parameter int no_of_units                     = DEFAULT_NO_OF_UNITS,
  parameter int number_of_equations_per_cluster = DEFAULT_EQUATIONS,
  parameter int address_width                   = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [element_width*no_of_units-1:0] a_vec,
  input  logic [element_width*no_of_units-1:0] b_vec,
  input  logic [element_width*no_of_units-1:0] c_vec,
  output logic [element_width*no_of_units-1:0] mem_data,
  output logic [address_width-1:0]             mem_address,
  output logic                                 mem_write_enable,
  output logic                                 busy,
  output logic                                 done
);

  localparam int WORDS = calc_words(number_of_equations_per_cluster, no_of_units);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             pipe_valid;
  logic             accept;
  logic [no_of_units-1:0] lane_live;

  assign accept = in_valid && in_ready;

  // mem_write_enable doubles as the second-stage valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      in_ready         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      beat_cnt         <= '0;
      pipe_valid       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
    end else begin
      pipe_valid       <= accept;
      mem_write_enable <= pipe_valid;
      if (mem_write_enable) begin
        mem_address <= mem_address + address_width'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            beat_cnt    <= '0;
            mem_address <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // The last beat leaves the sum stage this cycle, so done lands right after it.
          if (!pipe_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < no_of_units; k++) begin : g_lane
    assign lane_live[k] = (int'(beat_cnt) * no_of_units + k) < number_of_equations_per_cluster;

    mul_add_lane #(
      .element_width(element_width)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .advance(pipe_valid),
      .live   (lane_live[k]),
      .a      (a_vec[k*element_width +: element_width]),
      .b      (b_vec[k*element_width +: element_width]),
      .c      (c_vec[k*element_width +: element_width]),
      .result (mem_data[k*element_width +: element_width])
    );
  end

endmodule

// File: tb/tb_mul_add_stage.sv
// Scoreboard bench for mul_add_stage; expectations honour MUL_ADD_SATURATE_EN when defined.
module tb_mul_add_stage;

  localparam int EW    = 32;
  localparam int NU    = 8;
  localparam int NEQ   = 9;
  localparam int WORDS = 2;
  localparam int AW    = 32;
  localparam int VW    = EW * NU;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] a_vec;
  logic [VW-1:0] b_vec;
  logic [VW-1:0] c_vec;
  logic [VW-1:0] mem_data;
  logic [AW-1:0] mem_address;
  logic          mem_write_enable;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mul_add_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .a_vec           (a_vec),
    .b_vec           (b_vec),
    .c_vec           (c_vec),
    .mem_data        (mem_data),
    .mem_address     (mem_address),
    .mem_write_enable(mem_write_enable),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic [VW-1:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            last_write_cyc = -10;
  int            write_count = 0;
  int            done_count = 0;
  int            beat_idx = 0;
  logic [VW-1:0] seen_word[WORDS];

  task automatic checkOutput(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Reference: full-precision signed arithmetic, then wrap or clamp, with lanes past N forced to zero.
  function automatic logic [VW-1:0] model_word(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                               input logic [VW-1:0] c, input int word_idx);
    logic [VW-1:0] w;
    longint        r;
    logic [63:0]   r_bits;
    w = '0;
    for (int k = 0; k < NU; k++) begin
      if (word_idx * NU + k < NEQ) begin
        r = longint'($signed(a[k*EW +: EW])) * longint'($signed(b[k*EW +: EW]))
            + longint'($signed(c[k*EW +: EW]));
`ifdef MUL_ADD_SATURATE_EN
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
        r_bits = r;
        w[k*EW +: EW] = r_bits[EW-1:0];
      end
    end
    return w;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [EW-1:0] v);
    return {NU{v}};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < NU; k++) v[k*EW +: EW] = $urandom;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write must match the oldest outstanding beat.
  always @(negedge clk) begin
    exp_t e;
    if (mem_write_enable) begin
      write_count++;
      last_write_cyc = cyc;
      if (mem_address == 0) seen_word[0] = mem_data;
      else if (mem_address == 1) seen_word[1] = mem_data;
      if (exp_q.size() == 0) begin
        checkOutput("write_without_beat", VW'(1), VW'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_data", mem_data, e.data);
        checkOutput("write_address", VW'(mem_address), VW'(e.addr));
      end
    end
    if (done) begin
      done_count++;
      checkOutput("done_after_last_write", VW'(cyc), VW'(last_write_cyc + 1));
    end
  end

  task automatic applyStimulus(input logic [VW-1:0] a, input logic [VW-1:0] b,
                               input logic [VW-1:0] c, input int gap);
    bit got;
    int waited;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    a_vec    = a;
    b_vec    = b;
    c_vec    = c;
    in_valid = 1'b1;
    got      = 1'b0;
    waited   = 0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        exp_q.push_back('{data: model_word(a, b, c, beat_idx), addr: AW'(beat_idx)});
        beat_idx++;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!got) checkOutput("beat_accept_timeout", VW'(0), VW'(1));
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input bit start_on_done);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    if (!done) begin
      checkOutput("done_timeout", VW'(0), VW'(1));
    end else begin
      if (start_on_done) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic runPair(input logic [VW-1:0] a0, input logic [VW-1:0] b0, input logic [VW-1:0] c0,
                         input logic [VW-1:0] a1, input logic [VW-1:0] b1, input logic [VW-1:0] c1,
                         input int gap0, input int gap1, input string name);
    int w0;
    int d0;
    w0 = write_count;
    d0 = done_count;
    beat_idx = 0;
    pulseStart();
    applyStimulus(a0, b0, c0, gap0);
    applyStimulus(a1, b1, c1, gap1);
    waitDone(1'b0);
    checkOutput({name, "_writes"}, VW'(write_count - w0), VW'(2));
    checkOutput({name, "_dones"}, VW'(done_count - d0), VW'(1));
  endtask

  initial begin
    int w0;
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    c_vec    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags", VW'({in_ready, busy, done, mem_write_enable}), VW'(0));
    checkOutput("reset_address", VW'(mem_address), VW'(0));
    checkOutput("reset_data", mem_data, VW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    runPair(fill(3), fill(4), fill(5), fill(3), fill(4), fill(5), 0, 0, "basic");
    checkOutput("basic_w0_lane3", VW'(seen_word[0][3*EW +: EW]), VW'(17));
    checkOutput("basic_w1_lane0", VW'(seen_word[1][0 +: EW]), VW'(17));
    checkOutput("basic_w1_lane1", VW'(seen_word[1][1*EW +: EW]), VW'(0));

    runPair(fill(7), fill(-2), fill(1), fill(9), fill(9), fill(9), 0, 3, "stall");

    runPair(fill(32'h7FFF_FFFF), fill(2), fill(0), fill(32'h8000_0000), fill(2), fill(0), 0, 0, "overflow");
`ifdef MUL_ADD_SATURATE_EN
    checkOutput("overflow_pos", VW'(seen_word[0][0 +: EW]), VW'(32'h7FFF_FFFF));
    checkOutput("overflow_neg", VW'(seen_word[1][0 +: EW]), VW'(32'h8000_0000));
`else
    checkOutput("overflow_pos", VW'(seen_word[0][0 +: EW]), VW'(32'hFFFF_FFFE));
    checkOutput("overflow_neg", VW'(seen_word[1][0 +: EW]), VW'(32'h0000_0000));
`endif

    w0 = write_count;
    d0 = done_count;
    beat_idx = 0;
    pulseStart();
    applyStimulus(fill(1), fill(1), fill(1), 0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_flags", VW'({in_ready, busy, done, mem_write_enable}), VW'(0));
    checkOutput("midrst_address", VW'(mem_address), VW'(0));
    checkOutput("midrst_data", mem_data, VW'(0));
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst_no_writes", VW'(write_count - w0), VW'(0));
    checkOutput("midrst_no_done", VW'(done_count - d0), VW'(0));
    runPair(fill(2), fill(3), fill(4), fill(-1), fill(6), fill(1), 1, 0, "after_reset");

    w0 = write_count;
    d0 = done_count;
    beat_idx = 0;
    pulseStart();
    applyStimulus(fill(5), fill(5), fill(5), 0);
    pulseStart();
    applyStimulus(fill(6), fill(6), fill(6), 0);
    pulseStart();
    waitDone(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("start_on_done_idle", VW'({busy, in_ready}), VW'(0));
    checkOutput("start_busy_writes", VW'(write_count - w0), VW'(2));
    checkOutput("start_busy_dones", VW'(done_count - d0), VW'(1));
    @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) begin
      runPair(rand_vec(), rand_vec(), rand_vec(), rand_vec(), rand_vec(), rand_vec(),
              $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("queue_drained", VW'(exp_q.size()), VW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_add_stage.md
MUL_ADD_STAGE -- requirements
Module: mul_add_stage

Interface
REQ-001 The block SHALL have these parameters:
- element_width, default 32, lane width in bits.
- no_of_units, default 8, lanes per memory word.
- number_of_equations_per_cluster, default 9, valid result elements per run (N).
- address_width, default 32, width of mem_address.
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins a run.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_vec  in  element_width*no_of_units  multiplicand lanes.
- b_vec  in  element_width*no_of_units  multiplier lanes.
- c_vec  in  element_width*no_of_units  addend lanes.
- mem_data  out  element_width*no_of_units  packed results to the result memory.
- mem_address  out  address_width  result memory word address.
- mem_write_enable  out  1  result memory write strobe.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
REQ-003 Lane k SHALL occupy bits [k*element_width +: element_width] on every vector port.

Function
REQ-004 WORDS SHALL equal ceil(N/no_of_units); N=9, no_of_units=8 gives WORDS=2.
REQ-005 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-006 IDLE->RUN SHALL occur on start; start in any other state SHALL be ignored.
REQ-007 in_ready SHALL be 1 only in RUN; a beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-008 RUN->DRAIN SHALL occur on the cycle the WORDS-th beat is accepted.
REQ-009 DRAIN->DONE SHALL occur once the pipeline holds no valid beat; DONE->IDLE SHALL occur after one cycle.
REQ-010 done SHALL be 1 only in DONE.
REQ-011 busy SHALL be 1 in RUN and DRAIN.
REQ-012 Each lane SHALL compute a*b+c on signed operands as follows:
- the product is kept at full 2*element_width width;
- c is sign-extended before the add;
- the result is the low element_width bits (wrap) unless REQ-024 applies.
REQ-013 The pipeline SHALL have two register stages: product register, then sum register.
- A beat accepted at cycle t SHALL appear on mem_data with mem_write_enable=1 at cycle t+2.
REQ-014 mem_address SHALL start at 0 for each run and increment by 1 per write; it SHALL be held between writes.
REQ-015 In the last word, lanes with global index >= N SHALL be written as zero regardless of their inputs.
- N=9: last word lanes 1..7 are zero.
REQ-016 Gaps in in_valid SHALL stall the run without loss; bubbles SHALL produce no write.
REQ-017 mem_write_enable SHALL never assert outside RUN/DRAIN plus the 2-cycle pipeline tail, and never more than WORDS times per run.
REQ-018 A start arriving in the same cycle as done SHALL be ignored.

Reset
REQ-019 With rst_n=0 on a rising edge, the following SHALL be cleared:
- state to IDLE;
- pipeline valid bits;
- address counter;
- beat counter.
REQ-020 Output reset values SHALL be:
- in_ready, busy, done, mem_write_enable = 0;
- mem_address = 0;
- mem_data = 0.
REQ-021 A reset mid-run SHALL abort the run with no further writes and no done pulse.

Configuration
REQ-022 Macro MUL_ADD_SATURATE_EN SHALL select the lane overflow behaviour.
REQ-023 Without MUL_ADD_SATURATE_EN, results SHALL wrap as in REQ-012.
REQ-024 With MUL_ADD_SATURATE_EN, results outside the signed element_width range SHALL clamp to max 0x7FFFFFFF or min 0x80000000 (element_width=32).

Structure
REQ-025 Package mul_add_pkg SHALL hold:
- the FSM state typedef;
- the default width/lane constants;
- the WORDS computation function.
REQ-026 One sub-module, mul_add_lane, SHALL implement one lane's two-stage multiply-add and the saturation option; it SHALL be instantiated no_of_units times.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Basic run: start; 2 back-to-back beats with all lanes a=3, b=4, c=5 -> writes at addresses 0 and 1; word0 all lanes 17; word1 lane0=17, lanes1..7=0; done 1 cycle after the last write.
- Stall: in_valid low for 3 cycles between beats -> exactly 2 writes, addresses 0 and 1, no write during the gap.
- Overflow: a=0x7FFFFFFF, b=2, c=0 -> 0xFFFFFFFE without the macro; 0x7FFFFFFF with MUL_ADD_SATURATE_EN. Negative case a=0x80000000, b=2 -> 0x80000000 when saturating.
- Reset mid-run: rst_n low for 1 cycle after the first beat -> no further writes, no done; outputs 0; a new start then runs normally from address 0.
- start while busy, and start coincident with done -> ignored; write count stays 2 per run.
